// File: rtl/kamus_pkg.sv
// Shared types for the kamus core: write-back mux options, memory access sizes
// and the memory-stage FSM states.
package kamus_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ALU_RESULT = 2'b00,
    MEM_DATA   = 2'b01,
    NEXT_PC    = 2'b10,
    WB_RSVD    = 2'b11
  } wb_options_e;

  typedef enum logic [1:0] {
    MEM_BYTE     = 2'b00,
    MEM_HALF     = 2'b01,
    MEM_WORD     = 2'b10,
    MEM_WORD_ALT = 2'b11
  } mem_size_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } mem_state_e;

  // Encoding 11 behaves exactly like a word access.
  function automatic mem_size_e norm_size(input logic [1:0] raw);
    mem_size_e s;
    case (raw)
      2'b00:   s = MEM_BYTE;
      2'b01:   s = MEM_HALF;
      default: s = MEM_WORD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational load/store lane logic: store byte enables and lane replication,
// misalignment detection, and load-data extraction with sign/zero extension.
module kamus_lsu_align
  import kamus_pkg::*;
(
  input  logic [1:0]  acc_size_i,
  input  logic [1:0]  acc_off_i,
  input  logic        acc_is_store_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wr_data_o,
  output logic        misaligned_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  mem_size_e   w_acc_size;
  mem_size_e   w_ld_size;
  logic [3:0]  w_st_be;
  logic [31:0] w_shift;
  logic        w_sext;

  // Store lane steering and alignment check for the access currently in MEM.
  always_comb begin
    w_acc_size   = norm_size(acc_size_i);
    w_st_be      = 4'hF;
    wr_data_o    = st_data_i;
    misaligned_o = 1'b0;
    case (w_acc_size)
      MEM_BYTE: begin
        w_st_be   = 4'b0001 << acc_off_i;
        wr_data_o = {4{st_data_i[7:0]}};
      end
      MEM_HALF: begin
        w_st_be      = 4'b0011 << acc_off_i;
        wr_data_o    = {2{st_data_i[15:0]}};
        misaligned_o = acc_off_i[0];
      end
      default: begin
        misaligned_o = |acc_off_i;
      end
    endcase
    if (acc_is_store_i) begin
      be_o = w_st_be;
    end else begin
      be_o = 4'hF;
    end
  end

  // Load extract uses the offset/size captured when the load was granted.
  always_comb begin
    w_ld_size = norm_size(ld_size_i);
    w_shift   = ld_raw_i >> {ld_off_i, 3'b000};
    w_sext    = ~ld_unsigned_i;
    case (w_ld_size)
      MEM_BYTE: ld_data_o = {{24{w_sext & w_shift[7]}}, w_shift[7:0]};
      MEM_HALF: ld_data_o = {{16{w_sext & w_shift[15]}}, w_shift[15:0]};
      default:  ld_data_o = ld_raw_i;
    endcase
  end

endmodule

// File: rtl/kamus_mem_stage.sv
// Memory-access stage: issues L1D requests, waits for load responses, and owns
// the MEM/WB pipeline register; stalls upstream while an access is pending.
module kamus_mem_stage
  import kamus_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] ex_rslt_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_rd_en_i,
  input  logic        mem_wr_en_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic        regfile_wr_en_i,
  input  logic [1:0]  wb_mux_sel_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] next_pc_i,
  output logic        l1d_req_o,
  output logic        l1d_we_o,
  output logic [31:0] l1d_addr_o,
  output logic [3:0]  l1d_be_o,
  output logic [31:0] l1d_wr_data_o,
  input  logic        l1d_gnt_i,
  input  logic        l1d_rvalid_i,
  input  logic [31:0] l1d_rd_data_i,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        regfile_wr_en_o,
  output logic [31:0] ex_rslt_o,
  output logic [31:0] l1d_rd_data_o,
  output logic [1:0]  wb_mux_sel_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] next_pc_o
);

  mem_state_e  r_state;
  mem_state_e  w_next_state;

  logic        w_is_store;
  logic        w_is_load;
  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_misal_op;
  logic        w_req;
  logic        w_stall;
  logic        w_grant_load;
  logic [31:0] w_ld_data;

  logic        w_cap_wr_en;
  logic        w_cap_misal;
  logic [31:0] w_cap_rd_data;

  logic [1:0]  r_ld_size;
  logic [1:0]  r_ld_off;
  logic        r_ld_unsigned;

  logic        r_wr_en;
  logic        r_misal;
  logic [31:0] r_ex_rslt;
  logic [31:0] r_rd_data;
  wb_options_e r_wb_mux_sel;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_next_pc;

  assign w_is_store = mem_wr_en_i;
  assign w_is_load  = mem_rd_en_i & ~mem_wr_en_i;
  assign w_mem_op   = valid_i & (mem_rd_en_i | mem_wr_en_i);
  assign w_misal_op = w_mem_op & w_misaligned;

  kamus_lsu_align u_align (
    .acc_size_i     (mem_size_i),
    .acc_off_i      (ex_rslt_i[1:0]),
    .acc_is_store_i (w_is_store),
    .st_data_i      (store_data_i),
    .be_o           (l1d_be_o),
    .wr_data_o      (l1d_wr_data_o),
    .misaligned_o   (w_misaligned),
    .ld_size_i      (r_ld_size),
    .ld_off_i       (r_ld_off),
    .ld_unsigned_i  (r_ld_unsigned),
    .ld_raw_i       (l1d_rd_data_i),
    .ld_data_o      (w_ld_data)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, request and stall; a response seen in IDLE is simply ignored.
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    w_grant_load = 1'b0;
    if (rst_i) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op && !w_misaligned) begin
            w_req   = 1'b1;
            w_stall = ~l1d_gnt_i;
            if (l1d_gnt_i && w_is_load) begin
              w_next_state = WAIT_RSP;
              w_stall      = 1'b1;
              w_grant_load = 1'b1;
            end else begin
              w_next_state = IDLE;
            end
          end else begin
            w_next_state = IDLE;
          end
        end
        WAIT_RSP: begin
          if (l1d_rvalid_i) begin
            w_next_state = IDLE;
          end else begin
            w_stall = 1'b1;
          end
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // Values written into MEM/WB when the stage is not stalled.
  always_comb begin
    w_cap_wr_en   = valid_i & regfile_wr_en_i & ~w_misal_op;
    w_cap_misal   = 1'b0;
    w_cap_rd_data = 32'h0000_0000;
    if (r_state == WAIT_RSP) begin
      w_cap_rd_data = w_ld_data;
    end else begin
      w_cap_misal = w_misal_op;
    end
  end

  // Load offset/size/sign captured at grant, since EX/MEM may change afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ld_size     <= 2'b00;
      r_ld_off      <= 2'b00;
      r_ld_unsigned <= 1'b0;
    end else if (w_grant_load) begin
      r_ld_size     <= mem_size_i;
      r_ld_off      <= ex_rslt_i[1:0];
      r_ld_unsigned <= mem_unsigned_i;
    end
  end

  // MEM/WB register: stalled cycles insert a bubble, other fields hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_en      <= 1'b0;
      r_misal      <= 1'b0;
      r_ex_rslt    <= 32'h0000_0000;
      r_rd_data    <= 32'h0000_0000;
      r_wb_mux_sel <= ALU_RESULT;
      r_rd_addr    <= 5'd0;
      r_next_pc    <= 32'h0000_0000;
    end else if (w_stall) begin
      r_wr_en <= 1'b0;
      r_misal <= 1'b0;
    end else begin
      r_wr_en      <= w_cap_wr_en;
      r_misal      <= w_cap_misal;
      r_ex_rslt    <= ex_rslt_i;
      r_rd_data    <= w_cap_rd_data;
      r_wb_mux_sel <= wb_options_e'(wb_mux_sel_i);
      r_rd_addr    <= rd_addr_i;
      r_next_pc    <= next_pc_i;
    end
  end

  assign l1d_req_o       = w_req;
  assign l1d_we_o        = valid_i & w_is_store;
  assign l1d_addr_o      = {ex_rslt_i[31:2], 2'b00};
  assign stall_o         = w_stall;
  assign misaligned_o    = r_misal;
  assign regfile_wr_en_o = r_wr_en;
  assign ex_rslt_o       = r_ex_rslt;
  assign l1d_rd_data_o   = r_rd_data;
  assign wb_mux_sel_o    = r_wb_mux_sel;
  assign rd_addr_o       = r_rd_addr;
  assign next_pc_o       = r_next_pc;

endmodule

// File: tb/tb_kamus_mem_stage.sv
// Self-checking bench for kamus_mem_stage with a byte-arithmetic reference model.
module tb_kamus_mem_stage;
  import kamus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, mem_rd_en_i, mem_wr_en_i, mem_unsigned_i, regfile_wr_en_i;
  logic [31:0] ex_rslt_i, store_data_i, next_pc_i, l1d_rd_data_i;
  logic [1:0]  mem_size_i, wb_mux_sel_i;
  logic [4:0]  rd_addr_i;
  logic        l1d_gnt_i, l1d_rvalid_i;
  logic        l1d_req_o, l1d_we_o, stall_o, misaligned_o, regfile_wr_en_o;
  logic [31:0] l1d_addr_o, l1d_wr_data_o, ex_rslt_o, l1d_rd_data_o, next_pc_o;
  logic [3:0]  l1d_be_o;
  logic [1:0]  wb_mux_sel_o;
  logic [4:0]  rd_addr_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  kamus_mem_stage dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ex_rslt_i(ex_rslt_i),
    .store_data_i(store_data_i), .mem_rd_en_i(mem_rd_en_i), .mem_wr_en_i(mem_wr_en_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .regfile_wr_en_i(regfile_wr_en_i), .wb_mux_sel_i(wb_mux_sel_i),
    .rd_addr_i(rd_addr_i), .next_pc_i(next_pc_i),
    .l1d_req_o(l1d_req_o), .l1d_we_o(l1d_we_o), .l1d_addr_o(l1d_addr_o),
    .l1d_be_o(l1d_be_o), .l1d_wr_data_o(l1d_wr_data_o), .l1d_gnt_i(l1d_gnt_i),
    .l1d_rvalid_i(l1d_rvalid_i), .l1d_rd_data_i(l1d_rd_data_i),
    .stall_o(stall_o), .misaligned_o(misaligned_o), .regfile_wr_en_o(regfile_wr_en_o),
    .ex_rslt_o(ex_rslt_o), .l1d_rd_data_o(l1d_rd_data_o), .wb_mux_sel_o(wb_mux_sel_o),
    .rd_addr_o(rd_addr_o), .next_pc_o(next_pc_o)
  );

  // ---------------- reference model ----------------
  function automatic int ref_nbytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    else if (sz == 2'd1) return 2;
    else return 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic is_store, input logic [1:0] sz, input int off);
    int mask;
    if (!is_store) return 4'hF;
    mask = (1 << ref_nbytes(sz)) - 1;
    return 4'(mask << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    int nb;
    nb = ref_nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [1:0] sz,
                                           input int off, input logic uns);
    longint val;
    int nb;
    nb = ref_nbytes(sz);
    if (nb == 4) return raw;
    val = longint'(raw >> (8 * off)) % (longint'(1) << (8 * nb));
    if (!uns && val >= (longint'(1) << (8 * nb - 1))) val = val - (longint'(1) << (8 * nb));
    return val[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    valid_i = 1'b0; ex_rslt_i = 32'h0; store_data_i = 32'h0; mem_rd_en_i = 1'b0;
    mem_wr_en_i = 1'b0; mem_size_i = 2'b00; mem_unsigned_i = 1'b0; regfile_wr_en_i = 1'b0;
    wb_mux_sel_i = 2'b00; rd_addr_i = 5'd0; next_pc_i = 32'h0;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic wen,
                        input logic [1:0] sel, input logic [4:0] rda, input logic [31:0] npc);
    valid_i = 1'b1; mem_rd_en_i = rd; mem_wr_en_i = wr; mem_size_i = sz; mem_unsigned_i = uns;
    ex_rslt_i = addr; store_data_i = sdata; regfile_wr_en_i = wen; wb_mux_sel_i = sel;
    rd_addr_i = rda; next_pc_i = npc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [104:0] obs;
    clear_in();
    rst_i = 1'b1; l1d_gnt_i = 1'b1; l1d_rvalid_i = 1'b1; l1d_rd_data_i = 32'hFFFF_FFFF;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 2'b01, 5'd3, 32'h44);
    #1;
    n_total++;
    if ({l1d_req_o, stall_o} !== 2'b00) $display("FAIL reset_req_stall: got %b want 00", {l1d_req_o, stall_o});
    else n_pass++;
    tick(); tick();
    obs = {regfile_wr_en_o, ex_rslt_o, l1d_rd_data_o, wb_mux_sel_o, rd_addr_o, next_pc_o, misaligned_o};
    n_total++;
    if (obs !== 105'd0) $display("FAIL reset_memwb: got %h want 0", obs);
    else n_pass++;
    n_total++;
    if (wb_mux_sel_o !== ALU_RESULT) $display("FAIL reset_wbsel: got %b want %b", wb_mux_sel_o, ALU_RESULT);
    else n_pass++;
    clear_in();
    rst_i = 1'b0; l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    logic v, wen, rd, wr;
    logic [31:0] a, npc;
    logic [4:0] rda;
    logic [1:0] sel;
    set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 1'b1, ALU_RESULT, 5'd5, 32'h1238);
    #1;
    n_total++;
    if ({stall_o, l1d_req_o} !== 2'b00) $display("FAIL alu_stall: got %b want 00", {stall_o, l1d_req_o});
    else n_pass++;
    tick();
    n_total++;
    if ({ex_rslt_o, rd_addr_o, regfile_wr_en_o, misaligned_o, l1d_rd_data_o} !==
        {32'h1234, 5'd5, 1'b1, 1'b0, 32'h0})
      $display("FAIL alu_wb: got %h/%0d/%b want 1234/5/1", ex_rslt_o, rd_addr_o, regfile_wr_en_o);
    else n_pass++;
    for (int it = 0; it < 8; it++) begin
      v = 1'(it % 3 != 2); wen = 1'($urandom_range(0, 1)); a = $urandom(); npc = $urandom();
      rda = 5'($urandom_range(0, 31)); sel = 2'($urandom_range(0, 2));
      rd = 1'b0; wr = 1'b0;
      if (!v) begin rd = 1'($urandom_range(0, 1)); wr = ~rd; end
      set_op(rd, wr, 2'b10, 1'b0, a, $urandom(), wen, sel, rda, npc);
      valid_i = v;
      l1d_gnt_i = 1'($urandom_range(0, 1)); l1d_rvalid_i = 1'($urandom_range(0, 1));
      #1;
      n_total++;
      if ({stall_o, l1d_req_o} !== 2'b00) $display("FAIL alu_rand_req[%0d]: got %b want 00", it, {stall_o, l1d_req_o});
      else n_pass++;
      tick();
      n_total++;
      if ({ex_rslt_o, rd_addr_o, regfile_wr_en_o, wb_mux_sel_o, next_pc_o, l1d_rd_data_o} !==
          {a, rda, v & wen, sel, npc, 32'h0})
        $display("FAIL alu_rand_wb[%0d]: got %h %0d %b want %h %0d %b", it, ex_rslt_o, rd_addr_o,
                 regfile_wr_en_o, a, rda, v & wen);
      else n_pass++;
    end
    l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b0;
    clear_in();
  endtask

  task automatic test_store();
    logic [1:0] sz;
    logic [31:0] a, d;
    int off, nb, waits;
    set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h0, 1'b1, ALU_RESULT, 5'd9, 32'h60);
    tick();
    for (int it = 0; it < 7; it++) begin
      if (it == 0) begin
        sz = 2'b00; a = 32'h103; d = 32'hAB; waits = 2; off = 3;
      end else begin
        sz = 2'($urandom_range(0, 3)); nb = ref_nbytes(sz);
        off = (nb == 4) ? 0 : (nb == 2) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
        a = ($urandom() & 32'hFFFF_FFFC) | 32'(off); d = $urandom(); waits = $urandom_range(0, 2);
      end
      set_op(1'b0, 1'b1, sz, 1'b0, a, d, 1'b0, ALU_RESULT, 5'd0, 32'h200 + 32'(it));
      l1d_gnt_i = 1'b0;
      for (int w = 0; w < waits; w++) begin
        #1;
        n_total++;
        if ({l1d_req_o, l1d_we_o, stall_o, l1d_addr_o, l1d_be_o, l1d_wr_data_o} !==
            {3'b111, a & 32'hFFFF_FFFC, ref_be(1'b1, sz, off), ref_wdata(sz, d)})
          $display("FAIL store_req[%0d]: got req%b st%b be%b d%h want be%b d%h", it, l1d_req_o, stall_o,
                   l1d_be_o, l1d_wr_data_o, ref_be(1'b1, sz, off), ref_wdata(sz, d));
        else n_pass++;
        tick();
        if (it == 0) begin
          n_total++;
          if ({regfile_wr_en_o, misaligned_o, ex_rslt_o, rd_addr_o} !== {2'b00, 32'h55, 5'd9})
            $display("FAIL store_bubble: got wr%b ex%h rd%0d want wr0 ex55 rd9", regfile_wr_en_o, ex_rslt_o, rd_addr_o);
          else n_pass++;
        end
      end
      l1d_gnt_i = 1'b1;
      #1;
      n_total++;
      if ({l1d_req_o, stall_o, l1d_be_o} !== {2'b10, ref_be(1'b1, sz, off)})
        $display("FAIL store_gnt[%0d]: got req%b stall%b be%b", it, l1d_req_o, stall_o, l1d_be_o);
      else n_pass++;
      tick();
      l1d_gnt_i = 1'b0;
      n_total++;
      if ({ex_rslt_o, next_pc_o, regfile_wr_en_o, l1d_rd_data_o} !== {a, 32'h200 + 32'(it), 1'b0, 32'h0})
        $display("FAIL store_wb[%0d]: got ex%h pc%h want ex%h", it, ex_rslt_o, next_pc_o, a);
      else n_pass++;
    end
    clear_in();
  endtask

  task automatic test_load();
    logic [1:0] sz;
    logic [31:0] a, raw, exp;
    logic uns;
    logic [4:0] rda;
    int off, nb, delay;
    for (int it = 0; it < 10; it++) begin
      if (it < 2) begin
        sz = 2'b00; a = 32'h102; off = 2; raw = 32'h0080_0000; delay = 3; uns = 1'(it);
        exp = (it == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
      end else begin
        sz = 2'($urandom_range(0, 3)); nb = ref_nbytes(sz);
        off = (nb == 4) ? 0 : (nb == 2) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
        a = ($urandom() & 32'hFFFF_FFFC) | 32'(off); raw = $urandom(); delay = $urandom_range(1, 3);
        uns = 1'($urandom_range(0, 1)); exp = ref_load(raw, sz, off, uns);
      end
      rda = 5'($urandom_range(1, 31));
      set_op(1'b1, 1'b0, sz, uns, a, $urandom(), 1'b1, MEM_DATA, rda, 32'h300);
      l1d_gnt_i = 1'b1; l1d_rvalid_i = 1'b0;
      #1;
      n_total++;
      if ({l1d_req_o, l1d_we_o, stall_o, l1d_be_o, l1d_addr_o} !== {3'b101, 4'hF, a & 32'hFFFF_FFFC})
        $display("FAIL load_req[%0d]: got req%b we%b st%b be%b a%h", it, l1d_req_o, l1d_we_o, stall_o, l1d_be_o, l1d_addr_o);
      else n_pass++;
      tick();
      l1d_gnt_i = 1'b0;
      for (int w = 1; w < delay; w++) begin
        l1d_rd_data_i = $urandom();
        l1d_gnt_i = 1'($urandom_range(0, 1));
        #1;
        n_total++;
        if ({stall_o, l1d_req_o} !== 2'b10) $display("FAIL load_wait[%0d]: got %b want 10", it, {stall_o, l1d_req_o});
        else n_pass++;
        tick();
        n_total++;
        if (regfile_wr_en_o !== 1'b0) $display("FAIL load_bubble[%0d]: got %b want 0", it, regfile_wr_en_o);
        else n_pass++;
      end
      l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b1; l1d_rd_data_i = raw;
      #1;
      n_total++;
      if ({stall_o, l1d_req_o} !== 2'b00) $display("FAIL load_rvalid[%0d]: got %b want 00", it, {stall_o, l1d_req_o});
      else n_pass++;
      tick();
      l1d_rvalid_i = 1'b0; l1d_rd_data_i = $urandom();
      n_total++;
      if ({l1d_rd_data_o, regfile_wr_en_o, rd_addr_o, wb_mux_sel_o} !== {exp, 1'b1, rda, MEM_DATA})
        $display("FAIL load_data[%0d]: got %h wr%b rd%0d want %h wr1 rd%0d", it, l1d_rd_data_o,
                 regfile_wr_en_o, rd_addr_o, exp, rda);
      else n_pass++;
      clear_in();
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [4] = '{32'h201, 32'h202, 32'h303, 32'h301};
    logic [1:0]  sizes [4] = '{2'b01, 2'b10, 2'b01, 2'b11};
    for (int it = 0; it < 4; it++) begin
      set_op(1'(it < 2), 1'(it >= 2), sizes[it], 1'b0, addrs[it], 32'h1, 1'b1, MEM_DATA, 5'd4, 32'h0);
      l1d_gnt_i = 1'b1;
      #1;
      n_total++;
      if ({l1d_req_o, stall_o} !== 2'b00) $display("FAIL misal_req[%0d]: got %b want 00", it, {l1d_req_o, stall_o});
      else n_pass++;
      tick();
      n_total++;
      if ({misaligned_o, regfile_wr_en_o, ex_rslt_o} !== {2'b10, addrs[it]})
        $display("FAIL misal_wb[%0d]: got mis%b wr%b ex%h want mis1 wr0 ex%h", it, misaligned_o,
                 regfile_wr_en_o, ex_rslt_o, addrs[it]);
      else n_pass++;
      clear_in();
      l1d_gnt_i = 1'b0;
      tick();
      n_total++;
      if (misaligned_o !== 1'b0) $display("FAIL misal_pulse[%0d]: got %b want 0", it, misaligned_o);
      else n_pass++;
    end
  endtask

  task automatic test_reset_wait();
    logic [104:0] obs;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1, MEM_DATA, 5'd12, 32'h84);
    l1d_gnt_i = 1'b1;
    tick();
    l1d_gnt_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    n_total++;
    if ({l1d_req_o, stall_o} !== 2'b00) $display("FAIL rstwait_during: got %b want 00", {l1d_req_o, stall_o});
    else n_pass++;
    tick();
    rst_i = 1'b0;
    clear_in();
    l1d_rvalid_i = 1'b1; l1d_rd_data_i = 32'hDEAD_BEEF;
    #1;
    n_total++;
    if ({l1d_req_o, stall_o} !== 2'b00) $display("FAIL rstwait_stale: got %b want 00", {l1d_req_o, stall_o});
    else n_pass++;
    tick();
    l1d_rvalid_i = 1'b0;
    obs = {regfile_wr_en_o, ex_rslt_o, l1d_rd_data_o, wb_mux_sel_o, rd_addr_o, next_pc_o, misaligned_o};
    n_total++;
    if (obs !== 105'd0) $display("FAIL rstwait_memwb: got %h want 0", obs);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] raw, d;
    raw = $urandom(); d = $urandom();
    l1d_gnt_i = 1'b1;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, MEM_DATA, 5'd7, 32'h14);
    #1;
    n_total++;
    if ({l1d_req_o, stall_o} !== 2'b11) $display("FAIL b2b_lw_req: got %b want 11", {l1d_req_o, stall_o});
    else n_pass++;
    tick();
    l1d_rvalid_i = 1'b1; l1d_rd_data_i = raw;
    #1;
    n_total++;
    if ({l1d_req_o, stall_o} !== 2'b00) $display("FAIL b2b_outstanding: got %b want 00", {l1d_req_o, stall_o});
    else n_pass++;
    tick();
    l1d_rvalid_i = 1'b0;
    set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, d, 1'b0, ALU_RESULT, 5'd0, 32'h18);
    #1;
    n_total++;
    if ({l1d_req_o, l1d_we_o, stall_o, l1d_addr_o, l1d_wr_data_o} !== {3'b110, 32'h14, d})
      $display("FAIL b2b_sw_req: got req%b we%b st%b a%h", l1d_req_o, l1d_we_o, stall_o, l1d_addr_o);
    else n_pass++;
    n_total++;
    if ({l1d_rd_data_o, rd_addr_o, regfile_wr_en_o} !== {raw, 5'd7, 1'b1})
      $display("FAIL b2b_lw_wb: got %h rd%0d wr%b want %h rd7 wr1", l1d_rd_data_o, rd_addr_o, regfile_wr_en_o, raw);
    else n_pass++;
    tick();
    l1d_gnt_i = 1'b0;
    n_total++;
    if ({ex_rslt_o, regfile_wr_en_o, l1d_rd_data_o} !== {32'h14, 1'b0, 32'h0})
      $display("FAIL b2b_sw_wb: got ex%h wr%b d%h want ex14 wr0 d0", ex_rslt_o, regfile_wr_en_o, l1d_rd_data_o);
    else n_pass++;
    clear_in();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b0; l1d_rd_data_i = 32'h0; rst_i = 1'b1;
    clear_in();
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_misaligned();
    test_reset_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
